calc_port_responder: RTL and testbench
======================================

Name: calc_port_responder

Overview:
- Synthesizable single-port calc2 responder: accepts the calc2 request protocol (cmd/tag + operand 1, then operand 2), computes the result, returns tagged responses on the out_resp/out_data/out_tag channel.
- Serves as a drop-in model for one calc2 port, and as the building block for a four-port calc2 rebuild.
- Sits opposite the testbench driver/generator.

Parameters:
- DATA_W, 32, operand/result width.
- TAG_W, 2, tag width; also bounds outstanding requests.
- DEPTH, 4, max outstanding requests (accepted, not yet responded).
- ALU_LAT, 2, pipeline cycles from operand-2 capture to result-FIFO write (>=1).

Ports:
- c_clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_cmd_in  in  4  command; 0 = no-op.
- req_data_in  in  DATA_W  operand 1 in cmd cycle, operand 2 in following cycle.
- req_tag_in  in  TAG_W  tag, sampled in cmd cycle.
- out_resp  out  2  0 = none, 1 = success, 2 = overflow/underflow/invalid cmd.
- out_data  out  DATA_W  result; 0 when out_resp != 1.
- out_tag  out  TAG_W  tag of the response.
- req_busy  out  1  high when outstanding count == DEPTH.
- drop_cnt  out  8  saturating count of discarded commands.

Behaviour:
- Reset (reset=0, async): FSM to IDLE, pipeline and FIFO flushed, outstanding count 0, drop_cnt 0, all outputs 0. Any partial request is abandoned with no response.
- Capture FSM, IDLE -> OP2:
  - In IDLE, a cycle with cmd != 0 and req_busy=0 latches cmd, tag and op1, increments outstanding, and moves to OP2.
  - In OP2, the cycle latches op2 unconditionally, ignores req_cmd_in, and returns to IDLE.
- Back-to-back commands: a new cmd is legal in the cycle after OP2.
- Busy: a cmd in IDLE with req_busy=1 is discarded. The FSM stays in IDLE, the following data cycle is ignored, drop_cnt increments (saturates at 255), and no response is ever produced.
- ALU, all unsigned, result produced ALU_LAT cycles after op2 capture:
  - 1 ADD: op1+op2; carry out -> resp 2, data 0.
  - 2 SUB: op1-op2; op2 > op1 -> resp 2, data 0.
  - 5 SHL: op1 << op2[4:0], resp 1.
  - 6 SHR: op1 >> op2[4:0] (logical), resp 1.
  - Any other nonzero cmd: resp 2, data 0.
- Result FIFO: DEPTH entries, in-order. It cannot overflow because outstanding count <= DEPTH.
- Output stage: pops one entry per cycle and drives it for exactly one cycle. Otherwise out_resp, out_data and out_tag are all 0.
- Latency with an empty FIFO: response appears ALU_LAT+1 cycles after the op2 cycle (3 at defaults).
- Outstanding count decrements on the response cycle. Simultaneous accept and response leaves the count unchanged. A response freeing the last slot lets a cmd in the same cycle be accepted (busy is computed combinationally, including the pop).
- Responses are strictly in acceptance order. Duplicate tags are allowed unless the optional feature is enabled.

Optional Feature:
- CALC_TAG_CHECK_EN defined:
  - A 2^TAG_W-bit outstanding-tag vector is kept.
  - A cmd whose tag is already outstanding is still accepted and consumes its op2 cycle, but the ALU is bypassed and resp 2, data 0 is returned in order.
  - The tag bit is set on accept of a non-duplicate and cleared on its response.
- Undefined: no tag tracking; duplicates are computed normally.

Decomposition:
- Package calc_pkg holds:
  - cmd constants CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6;
  - resp constants RESP_NONE=0, RESP_OK=1, RESP_ERR=2;
  - default widths;
  - packed structs calc_req_t {cmd, tag, op1, op2} and calc_resp_t {resp, data, tag}.
- Sub-module calc_alu_pipe: computes from calc_req_t, with ALU_LAT delay stages and a valid bit.
- Capture FSM, FIFO and counters stay in the top.

Test Plan:
- ADD tag 1: cycle0 cmd=1 data=0x0000_0005, cycle1 data=0x0000_0007 -> cycle4: resp=1, data=0x0000_000C, tag=1; all outputs 0 elsewhere.
- ADD overflow 0xFFFF_FFFF+0x1 -> resp=2, data=0. SUB 3-5 -> resp=2. SUB 9-4 -> resp=1, data=5.
- SHL 0x1 by 0x23 -> data=0x0000_0008 (uses op2[4:0]=3). SHR 0x8000_0000 by 31 -> data=0x1. cmd=3 -> resp=2.
- Four back-to-back ADDs with tags 0..3 -> req_busy=1 after the 4th cmd; a 5th cmd is dropped (drop_cnt=1, no 5th response); responses appear in tag order 0,1,2,3.
- Assert reset=0 between cmd and op2 cycles -> no response ever; outputs 0 immediately (async); next request behaves normally.
- With CALC_TAG_CHECK_EN: two ADDs both tag 2 back-to-back -> first resp=1 with sum, second resp=2, data 0. Without the macro both return sums.

Source files
------------

// File: rtl/calc_pkg.sv
// Purpose : shared command/response encodings, default widths and bus structs for calc2 ports.
// Latency : n/a (types and constants only).
// Backpr. : n/a.
package calc_pkg;

    localparam int CALC_DATA_W  = 32;
    localparam int CALC_TAG_W   = 2;
    localparam int CALC_DEPTH   = 4;
    localparam int CALC_ALU_LAT = 2;
    localparam int CMD_W        = 4;
    localparam int RESP_W       = 2;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

    // Struct fields are sized by the package widths; modules that take
    // DATA_W/TAG_W parameters must be built with matching values.
    typedef struct packed {
        logic [CMD_W-1:0]       cmd;
        logic [CALC_TAG_W-1:0]  tag;
        logic [CALC_DATA_W-1:0] op1;
        logic [CALC_DATA_W-1:0] op2;
    } calc_req_t;

    typedef struct packed {
        logic [RESP_W-1:0]      resp;
        logic [CALC_DATA_W-1:0] data;
        logic [CALC_TAG_W-1:0]  tag;
    } calc_resp_t;

endpackage

// File: rtl/calc_alu_pipe.sv
// Purpose : evaluates one calc2 request and delays the tagged result through ALU_LAT register stages.
// Latency : ALU_LAT cycles from in_vld_i to out_vld_o.
// Backpr. : none; the caller guarantees space downstream for every issued request.
// Ports   : clk_i/rst_ni clock and async active-low reset; in_vld_i/in_req_i request in;
//           out_vld_o/out_resp_o response out (data already 0 on any error).
module calc_alu_pipe
    import calc_pkg::*;
#(
    parameter int ALU_LAT = CALC_ALU_LAT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       in_vld_i,
    input  calc_req_t  in_req_i,
    output logic       out_vld_o,
    output calc_resp_t out_resp_o
);

    // Unsigned arithmetic; every unrecognised command yields RESP_ERR with zero data.
    function automatic calc_resp_t alu_eval(input calc_req_t r);
        calc_resp_t             res;
        logic [CALC_DATA_W:0]   wide;
        res.resp = RESP_ERR;
        res.data = '0;
        res.tag  = r.tag;
        wide     = '0;
        case (r.cmd)
            CMD_ADD: begin
                wide = {1'b0, r.op1} + {1'b0, r.op2};
                if (!wide[CALC_DATA_W]) begin
                    res.resp = RESP_OK;
                    res.data = wide[CALC_DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (r.op2 <= r.op1) begin
                    res.resp = RESP_OK;
                    res.data = r.op1 - r.op2;
                end
            end
            CMD_SHL: begin
                res.resp = RESP_OK;
                res.data = r.op1 << r.op2[4:0];
            end
            CMD_SHR: begin
                res.resp = RESP_OK;
                res.data = r.op1 >> r.op2[4:0];
            end
            default: ;
        endcase
        return res;
    endfunction

    logic [ALU_LAT-1:0] vld_q;
    calc_resp_t         stage_q [ALU_LAT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            for (int i = 0; i < ALU_LAT; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            vld_q[0]   <= in_vld_i;
            stage_q[0] <= alu_eval(in_req_i);
            for (int i = 1; i < ALU_LAT; i++) begin
                vld_q[i]   <= vld_q[i-1];
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign out_vld_o  = vld_q[ALU_LAT-1];
    assign out_resp_o = stage_q[ALU_LAT-1];

endmodule

// File: rtl/calc_port_responder.sv
// Purpose : single calc2 port responder: capture FSM, ALU pipe, in-order result FIFO, busy/drop accounting.
// Latency : response appears ALU_LAT+1 cycles after the op2 cycle when the result FIFO is empty.
// Backpr. : req_busy when DEPTH requests are outstanding; a cmd seen while busy is dropped and counted.
// Ports   : c_clk/reset clock and async active-low reset; req_cmd_in/req_data_in/req_tag_in request
//           channel; out_resp/out_data/out_tag one-cycle response; req_busy, drop_cnt status.
// Option  : define CALC_TAG_CHECK_EN to return RESP_ERR for a cmd whose tag is already outstanding.
module calc_port_responder
    import calc_pkg::*;
#(
    parameter int DATA_W  = CALC_DATA_W,
    parameter int TAG_W   = CALC_TAG_W,
    parameter int DEPTH   = CALC_DEPTH,
    parameter int ALU_LAT = CALC_ALU_LAT
) (
    input  logic              c_clk,
    input  logic              reset,
    input  logic [3:0]        req_cmd_in,
    input  logic [DATA_W-1:0] req_data_in,
    input  logic [TAG_W-1:0]  req_tag_in,
    output logic [1:0]        out_resp,
    output logic [DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]  out_tag,
    output logic              req_busy,
    output logic [7:0]        drop_cnt
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_SKIP} state_e;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    state_e             state_q;
    logic [3:0]         cmd_q;
    logic [TAG_W-1:0]   tag_q;
    logic [DATA_W-1:0]  op1_q;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;

    calc_resp_t         fifo_mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   fifo_cnt_q;

    logic               cmd_vld, pop, busy, accept, drop;
    logic [3:0]         cmd_eff;
    calc_req_t          alu_req;
    logic               alu_out_vld;
    calc_resp_t         alu_out;
    calc_resp_t         head;

    assign cmd_vld = (req_cmd_in != CMD_NOP);
    // The output stage pops whenever the FIFO holds anything, so a slot freed
    // this cycle is already visible to the accept decision.
    assign pop     = (fifo_cnt_q != '0);
    assign busy    = (out_cnt_q == CNT_W'(DEPTH)) && !pop;
    assign accept  = (state_q == ST_IDLE) && cmd_vld && !busy;
    assign drop    = (state_q == ST_IDLE) && cmd_vld && busy;
    assign head    = fifo_mem_q[rd_ptr_q];

    // Capture FSM: cmd/tag/op1 in IDLE, op2 taken straight into the ALU in OP2.
    // SKIP swallows the data cycle that follows a dropped cmd.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            tag_q   <= '0;
            op1_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        cmd_q   <= req_cmd_in;
                        tag_q   <= req_tag_in;
                        op1_q   <= req_data_in;
                        state_q <= ST_OP2;
                    end else if (drop) begin
                        state_q <= ST_SKIP;
                    end
                end
                ST_OP2:  state_q <= ST_IDLE;
                ST_SKIP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef CALC_TAG_CHECK_EN
    // Any code outside the decoded command set makes the ALU return RESP_ERR/0,
    // which is exactly the duplicate-tag answer.
    localparam logic [3:0] CMD_FORCE_ERR = 4'hF;

    logic [2**TAG_W-1:0] tag_busy_q, tag_busy_d;
    logic                dup_q;
    logic [DEPTH-1:0]    dup_fifo_q;   // per-request dup flag, in acceptance order
    logic [PTR_W-1:0]    dwr_ptr_q, drd_ptr_q;
    logic                is_dup;

    assign is_dup  = tag_busy_q[req_tag_in];
    assign cmd_eff = dup_q ? CMD_FORCE_ERR : cmd_q;

    // Only the request that set a tag bit may clear it; set and clear never hit
    // the same bit in one cycle because a set requires the bit to be clear.
    always_comb begin
        tag_busy_d = tag_busy_q;
        if (pop && !dup_fifo_q[drd_ptr_q]) begin
            tag_busy_d[head.tag] = 1'b0;
        end
        if (accept && !is_dup) begin
            tag_busy_d[req_tag_in] = 1'b1;
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            tag_busy_q <= '0;
            dup_q      <= 1'b0;
            dup_fifo_q <= '0;
            dwr_ptr_q  <= '0;
            drd_ptr_q  <= '0;
        end else begin
            tag_busy_q <= tag_busy_d;
            if (accept) begin
                dup_q                 <= is_dup;
                dup_fifo_q[dwr_ptr_q] <= is_dup;
                dwr_ptr_q             <= ptr_inc(dwr_ptr_q);
            end
            if (pop) begin
                drd_ptr_q <= ptr_inc(drd_ptr_q);
            end
        end
    end
`else
    assign cmd_eff = cmd_q;
`endif

    always_comb begin
        alu_req     = '0;
        alu_req.cmd = cmd_eff;
        alu_req.tag = tag_q;
        alu_req.op1 = op1_q;
        alu_req.op2 = req_data_in;
    end

    calc_alu_pipe #(
        .ALU_LAT (ALU_LAT)
    ) u_alu (
        .clk_i      (c_clk),
        .rst_ni     (reset),
        .in_vld_i   (state_q == ST_OP2),
        .in_req_i   (alu_req),
        .out_vld_o  (alu_out_vld),
        .out_resp_o (alu_out)
    );

    // Result FIFO: never overflows since entries <= outstanding <= DEPTH.
    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem_q[i] <= '0;
            end
        end else begin
            if (alu_out_vld) begin
                fifo_mem_q[wr_ptr_q] <= alu_out;
                wr_ptr_q             <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (alu_out_vld && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + 1'b1;
            end else if (!alu_out_vld && pop) begin
                fifo_cnt_q <= fifo_cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (accept && !pop) begin
            out_cnt_d = out_cnt_q + 1'b1;
        end else if (!accept && pop) begin
            out_cnt_d = out_cnt_q - 1'b1;
        end
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // The FIFO head is driven for the single cycle it is popped; zero otherwise.
    assign out_resp = pop ? head.resp : RESP_NONE;
    assign out_data = pop ? head.data : '0;
    assign out_tag  = pop ? head.tag  : '0;
    assign req_busy = busy;
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_calc_port_responder.sv
module tb_calc_port_responder;
    import calc_pkg::*;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [3:0]  req_cmd;
    logic [31:0] req_data;
    logic [1:0]  req_tag;

    logic [1:0]  a_resp, b_resp;
    logic [31:0] a_data, b_data;
    logic [1:0]  a_tag, b_tag;
    logic        a_busy, b_busy;
    logic [7:0]  a_drop, b_drop;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 c_clk = ~c_clk;

    calc_port_responder dut_a (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd),
        .req_data_in (req_data),
        .req_tag_in  (req_tag),
        .out_resp    (a_resp),
        .out_data    (a_data),
        .out_tag     (a_tag),
        .req_busy    (a_busy),
        .drop_cnt    (a_drop)
    );

    // Long-latency instance so four outstanding requests actually fill the port.
    calc_port_responder #(.ALU_LAT(8)) dut_b (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd),
        .req_data_in (req_data),
        .req_tag_in  (req_tag),
        .out_resp    (b_resp),
        .out_data    (b_data),
        .out_tag     (b_tag),
        .req_busy    (b_busy),
        .drop_cnt    (b_drop)
    );

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } rsp_t;

    rsp_t qa[$];
    rsp_t qb[$];

    always @(negedge c_clk) begin
        if (a_resp != 2'd0) qa.push_back('{resp: a_resp, data: a_data, tag: a_tag});
        if (b_resp != 2'd0) qb.push_back('{resp: b_resp, data: b_data, tag: b_tag});
    end

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  tag;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] d, input logic [1:0] t);
        req_cmd  = c;
        req_data = d;
        req_tag  = t;
        @(posedge c_clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        req_cmd  = '0;
        req_data = '0;
        req_tag  = '0;
        repeat (2) @(posedge c_clk);
        #1;
        reset = 1'b1;
        @(posedge c_clk);
        #1;
    endtask

    initial begin
        vec_t        vecs [11];
        int          found;
        rsp_t        got;
        logic [1:0]  after_resp;
        logic [31:0] after_data;
        logic [1:0]  exp_tag_b [5];
        logic [31:0] exp_dat_b [5];
        logic [1:0]  exp_rsp_b [5];

        vecs[0]  = '{CMD_ADD, 32'h0000_0005, 32'h0000_0007, 2'd1, RESP_OK,  32'h0000_000C};
        vecs[1]  = '{CMD_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 2'd0, RESP_ERR, 32'h0};
        vecs[2]  = '{CMD_SUB, 32'd3,         32'd5,         2'd2, RESP_ERR, 32'h0};
        vecs[3]  = '{CMD_SUB, 32'd9,         32'd4,         2'd3, RESP_OK,  32'd5};
        vecs[4]  = '{CMD_SHL, 32'h0000_0001, 32'h0000_0023, 2'd1, RESP_OK,  32'h0000_0008};
        vecs[5]  = '{CMD_SHR, 32'h8000_0000, 32'd31,        2'd2, RESP_OK,  32'h0000_0001};
        vecs[6]  = '{4'd3,    32'd10,        32'd20,        2'd3, RESP_ERR, 32'h0};
        vecs[7]  = '{4'd15,   32'd10,        32'd20,        2'd0, RESP_ERR, 32'h0};
        vecs[8]  = '{CMD_ADD, 32'h0,         32'h0,         2'd1, RESP_OK,  32'h0};
        vecs[9]  = '{CMD_SHL, 32'hFFFF_FFFF, 32'h0,         2'd2, RESP_OK,  32'hFFFF_FFFF};
        vecs[10] = '{CMD_SUB, 32'd7,         32'd7,         2'd3, RESP_OK,  32'h0};

        // Reset state, checked before any clock edge.
        reset    = 1'b0;
        req_cmd  = '0;
        req_data = '0;
        req_tag  = '0;
        #2;
        chk("rst_resp", 64'(a_resp), 64'd0);
        chk("rst_data", 64'(a_data), 64'd0);
        chk("rst_tag",  64'(a_tag),  64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_drop", 64'(a_drop), 64'd0);
        repeat (2) @(posedge c_clk);
        #1;
        reset = 1'b1;
        @(posedge c_clk);
        #1;

        // Table-driven ALU vectors: exact latency, value, and one-cycle response.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].cmd, vecs[i].op1, vecs[i].tag);
            drive(4'd0, vecs[i].op2, 2'd0);
            req_data   = '0;
            found      = 0;
            got        = '0;
            after_resp = 2'd3;
            after_data = 32'hDEAD_BEEF;
            for (int n = 1; n <= 6; n++) begin
                if (found != 0 && n == found + 1) begin
                    after_resp = a_resp;
                    after_data = a_data;
                end
                if (found == 0 && a_resp != 2'd0) begin
                    found = n;
                    got   = '{resp: a_resp, data: a_data, tag: a_tag};
                end
                @(posedge c_clk);
                #1;
            end
            chk($sformatf("vec%0d_latency", i), 64'(found),      64'd3);
            chk($sformatf("vec%0d_resp", i),    64'(got.resp),   64'(vecs[i].exp_resp));
            chk($sformatf("vec%0d_data", i),    64'(got.data),   64'(vecs[i].exp_data));
            chk($sformatf("vec%0d_tag", i),     64'(got.tag),    64'(vecs[i].tag));
            chk($sformatf("vec%0d_after", i),   {30'd0, after_resp, after_data}, 64'd0);
        end

        // Duplicate tags back to back.
        do_reset();
        qa.delete();
        drive(CMD_ADD, 32'd10, 2'd2);
        drive(4'd0,    32'd20, 2'd0);
        drive(CMD_ADD, 32'd30, 2'd2);
        drive(4'd0,    32'd40, 2'd0);
        repeat (8) drive(4'd0, 32'd0, 2'd0);
        chk("dup_count", 64'(qa.size()), 64'd2);
        if (qa.size() >= 2) begin
            chk("dup0_resp", 64'(qa[0].resp), 64'(RESP_OK));
            chk("dup0_data", 64'(qa[0].data), 64'd30);
            chk("dup1_tag",  64'(qa[1].tag),  64'd2);
`ifdef CALC_TAG_CHECK_EN
            chk("dup1_resp", 64'(qa[1].resp), 64'(RESP_ERR));
            chk("dup1_data", 64'(qa[1].data), 64'd0);
`else
            chk("dup1_resp", 64'(qa[1].resp), 64'(RESP_OK));
            chk("dup1_data", 64'(qa[1].data), 64'd70);
`endif
        end

        // Reset mid-request: outputs clear asynchronously, nothing emerges afterwards.
        do_reset();
        drive(CMD_ADD, 32'd100, 2'd1);
        drive(4'd0,    32'd23,  2'd0);
        drive(4'd0,    32'd0,   2'd0);
        drive(4'd0,    32'd0,   2'd0);
        chk("pre_rst_resp", 64'(a_resp), 64'(RESP_OK));
        chk("pre_rst_data", 64'(a_data), 64'd123);
        req_cmd  = CMD_ADD;
        req_data = 32'd5;
        req_tag  = 2'd3;
        #2;
        reset = 1'b0;
        #1;
        chk("async_rst_out", {28'd0, a_resp, a_tag, a_data}, 64'd0);
        @(posedge c_clk);
        #1;
        req_cmd  = '0;
        req_data = 32'd7;
        req_tag  = '0;
        @(posedge c_clk);
        #1;
        reset = 1'b1;
        qa.delete();
        repeat (12) drive(4'd0, 32'd0, 2'd0);
        chk("rst_no_resp", 64'(qa.size()), 64'd0);
        drive(CMD_ADD, 32'h20, 2'd2);
        drive(4'd0,    32'h22, 2'd0);
        repeat (6) drive(4'd0, 32'd0, 2'd0);
        chk("post_rst_count", 64'(qa.size()), 64'd1);
        if (qa.size() >= 1) begin
            chk("post_rst_rsp", {30'd0, qa[0].resp, qa[0].data}, {30'd0, RESP_OK, 32'h42});
            chk("post_rst_tag", 64'(qa[0].tag), 64'd2);
        end

        // Fill the long-latency port: busy, drop, same-cycle free, in-order return.
        do_reset();
        qb.delete();
        for (int t = 0; t < 4; t++) begin
            drive(CMD_ADD, 32'(32'h10 * (t + 1)), 2'(t));
            drive(4'd0, 32'(t), 2'd0);
        end
        chk("busy_full", 64'(b_busy), 64'd1);
        drive(CMD_ADD, 32'h100, 2'd0);
        drive(4'd0, 32'h200, 2'd0);
        chk("drop_one",     64'(b_drop), 64'd1);
        chk("busy_on_free", 64'(b_busy), 64'd0);
        drive(CMD_ADD, 32'h1000, 2'd1);
        drive(4'd0, 32'h234, 2'd0);
        repeat (16) drive(4'd0, 32'd0, 2'd0);

        exp_tag_b = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1};
        exp_dat_b = '{32'h10, 32'h21, 32'h32, 32'h43, 32'h1234};
        exp_rsp_b = '{RESP_OK, RESP_OK, RESP_OK, RESP_OK, RESP_OK};
`ifdef CALC_TAG_CHECK_EN
        exp_dat_b[4] = 32'h0;
        exp_rsp_b[4] = RESP_ERR;
`endif
        chk("fill_count", 64'(qb.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < qb.size()) begin
                chk($sformatf("fill%0d_tag", k),  64'(qb[k].tag),  64'(exp_tag_b[k]));
                chk($sformatf("fill%0d_data", k), 64'(qb[k].data), 64'(exp_dat_b[k]));
                chk($sformatf("fill%0d_resp", k), 64'(qb[k].resp), 64'(exp_rsp_b[k]));
            end
        end
        chk("drop_final", 64'(b_drop), 64'd1);
        chk("busy_final", 64'(b_busy), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
